// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first.
// Define BCD_SUB_EN to honour the sub input; otherwise every operation is an add.
//
// state | meaning
// IDLE  | waiting for start; sum/carry hold the last result
// RUN   | processing one digit per edge, DIGITS edges in total
// DONE  | one-cycle done pulse, then back to IDLE
module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_q, b_q;
    logic            c_q;
    logic [IW-1:0]   idx;
    logic            last;
    logic            sub_in, sub_q;
    logic [3:0]      b_dig, dig;
    logic [4:0]      t;
    logic            c_nxt;

    function automatic logic has_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

`ifdef BCD_SUB_EN
    assign sub_in = sub;
    assign b_dig  = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];

    always_ff @(posedge clk) begin
        if (rst)
            sub_q <= 1'b0;
        else if (state == IDLE && start)
            sub_q <= sub;
    end
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_in     = 1'b0;
    assign sub_q      = 1'b0;
    assign b_dig      = b_q[3:0];
`endif

    assign last = (idx == IW'(DIGITS - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Operands shift right each digit, so the active digit is always [3:0].
    always_comb begin
        t     = {1'b0, a_q[3:0]} + {1'b0, b_dig} + {4'b0000, c_q};
        dig   = t[3:0];
        c_nxt = 1'b0;
        if (t > 5'd9) begin
            dig   = t[3:0] + 4'd6;
            c_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                        c_q <= cin ^ sub_in;
                        idx <= '0;
                        sum <= '0;
                        err <= has_bad(a) | has_bad(b);
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= dig;
                    a_q <= a_q >> 4;
                    b_q <= b_q >> 4;
                    c_q <= c_nxt;
                    idx <= idx + 1'b1;
                    if (last)
                        carry <= c_nxt ^ sub_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Bench for bcd_addsub_serial (DIGITS=4): directed vectors plus randomized
// back-to-back operations against a decimal/digit-rule reference model.
module tb_bcd_addsub_serial;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic          clk = 1'b0;
    logic          rst, start, cin, sub;
    logic [W-1:0]  a, b, sum;
    logic          carry, busy, done, err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0]  o_sum, o_sum_hold;
    logic          o_carry, o_carry_hold, o_err, o_err0, o_done_after;
    int            o_lat, o_busy_cnt;

    always #5 clk = ~clk;

    bcd_addsub_serial #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .sum(sum), .carry(carry), .busy(busy), .done(done), .err(err)
    );

    function automatic logic bad(input logic [W-1:0] v);
        for (int i = 0; i < D; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int to_dec(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] from_dec(input int r);
        logic [W-1:0] v;
        int x = r;
        for (int i = 0; i < D; i++) begin
            v[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    // Valid operands: plain decimal arithmetic. Invalid digits: per-digit rule mod 16.
    task automatic model(input logic [W-1:0] av, bv, input logic cv, sv,
                         output logic [W-1:0] es, output logic ec);
        bit s;
        int lim = 1;
`ifdef BCD_SUB_EN
        s = sv;
`else
        s = 1'b0;
`endif
        for (int i = 0; i < D; i++) lim = lim * 10;
        if (!bad(av) && !bad(bv)) begin
            int r;
            if (!s) begin
                r  = to_dec(av) + to_dec(bv) + int'(cv);
                ec = (r >= lim);
                es = from_dec(r % lim);
            end else begin
                r  = to_dec(av) - to_dec(bv) - int'(cv);
                ec = (r < 0);
                es = from_dec(r < 0 ? r + lim : r);
            end
        end else begin
            int c = s ? int'(!cv) : int'(cv);
            for (int i = 0; i < D; i++) begin
                int ad = int'(av[4*i +: 4]);
                int bd = int'(bv[4*i +: 4]);
                int tt;
                if (s) bd = (9 - bd) & 15;
                tt = ad + bd + c;
                if (tt > 9) begin
                    es[4*i +: 4] = 4'((tt + 6) % 16);
                    c = 1;
                end else begin
                    es[4*i +: 4] = 4'(tt);
                    c = 0;
                end
            end
            ec = s ? (c == 0) : (c == 1);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_op(input logic [W-1:0] av, bv, input logic cv, sv, input bit noise);
        a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        o_err0 = err;
        o_lat = 0;
        o_busy_cnt = 0;
        while (!done && o_lat < 50) begin
            if (busy) o_busy_cnt++;
            if (noise) begin
                a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom); start = 1'($urandom);
            end
            @(negedge clk);
            o_lat++;
        end
        start = 1'b0;
        o_sum = sum; o_carry = carry; o_err = err;
        @(negedge clk);
        o_done_after = done; o_sum_hold = sum; o_carry_hold = carry;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b1; sub = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({sum, carry, busy, done, err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: sum=%h carry=%b busy=%b done=%b err=%b, need all 0",
                     sum, carry, busy, done, err);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_priority: busy=%b after reset with start held, need 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3] = '{16'h1234, 16'h9999, 16'h9999};
        logic [W-1:0] vb [3] = '{16'h5678, 16'h0001, 16'h9999};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] xs [3] = '{16'h6912, 16'h0000, 16'h9999};
        logic         xc [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vc[i], 1'b0, 1'b0);
            tests_run++;
            if (o_lat !== D || o_busy_cnt !== D || o_sum !== xs[i] || o_carry !== xc[i] || o_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_add%0d: lat=%0d busy=%0d sum=%h c=%b err=%b, need lat=%0d busy=%0d sum=%h c=%b err=0",
                         i, o_lat, o_busy_cnt, o_sum, o_carry, o_err, D, D, xs[i], xc[i]);
            end
            tests_run++;
            if (o_done_after !== 1'b0 || o_sum_hold !== xs[i] || o_carry_hold !== xc[i]) begin
                tests_failed++;
                $display("FAIL directed_hold%0d: done=%b sum=%h c=%b, need done=0 sum=%h c=%b",
                         i, o_done_after, o_sum_hold, o_carry_hold, xs[i], xc[i]);
            end
        end
    endtask

    task automatic test_sub();
`ifdef BCD_SUB_EN
        logic [W-1:0] xs [2] = '{16'h0099, 16'h9999};
        logic         xc [2] = '{1'b0, 1'b1};
        logic [W-1:0] va [2] = '{16'h0100, 16'h0000};
`else
        logic [W-1:0] xs [2] = '{16'h0101, 16'h0001};
        logic         xc [2] = '{1'b0, 1'b0};
        logic [W-1:0] va [2] = '{16'h0100, 16'h0000};
`endif
        for (int i = 0; i < 2; i++) begin
            do_op(va[i], 16'h0001, 1'b0, 1'b1, 1'b0);
            tests_run++;
            if (o_lat !== D || o_sum !== xs[i] || o_carry !== xc[i]) begin
                tests_failed++;
                $display("FAIL sub%0d: lat=%0d sum=%h c=%b, need lat=%0d sum=%h c=%b",
                         i, o_lat, o_sum, o_carry, D, xs[i], xc[i]);
            end
        end
    endtask

    task automatic test_err();
        do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (o_err0 !== 1'b1 || o_err !== 1'b1 || o_sum !== 16'h0100 || o_carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_set: err0=%b err=%b sum=%h c=%b, need err0=1 err=1 sum=0100 c=0",
                     o_err0, o_err, o_sum, o_carry);
        end
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (o_err0 !== 1'b0 || o_sum !== 16'h3333) begin
            tests_failed++;
            $display("FAIL err_clear: err0=%b sum=%h, need err0=0 sum=3333", o_err0, o_sum);
        end
    endtask

    task automatic test_abort();
        bit seen_done = 1'b0;
        a = 16'h1234; b = 16'h5678; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({sum, carry, busy, done, err} !== '0) begin
            tests_failed++;
            $display("FAIL abort_state: sum=%h carry=%b busy=%b done=%b err=%b, need all 0",
                     sum, carry, busy, done, err);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) seen_done = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (seen_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: activity seen=%b, need 0", seen_done);
        end
    endtask

    task automatic test_start_ignored();
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (o_lat !== D || o_busy_cnt !== D || o_sum !== 16'h6912 || o_carry !== 1'b0 || o_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_ignored: lat=%0d busy=%0d sum=%h c=%b err=%b, need lat=%0d busy=%0d sum=6912 c=0 err=0",
                     o_lat, o_busy_cnt, o_sum, o_carry, o_err, D, D);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] av, bv, es;
            logic         cv, sv, ec, ee;
            if (n % 4 == 3) begin
                av = W'($urandom);
                bv = W'($urandom);
            end else begin
                for (int i = 0; i < D; i++) begin
                    av[4*i +: 4] = 4'($urandom_range(9));
                    bv[4*i +: 4] = 4'($urandom_range(9));
                end
            end
            cv = 1'($urandom);
            sv = 1'($urandom);
            model(av, bv, cv, sv, es, ec);
            ee = bad(av) | bad(bv);
            do_op(av, bv, cv, sv, bit'($urandom_range(1)));
            tests_run++;
            if (o_lat !== D || o_busy_cnt !== D || o_sum !== es || o_carry !== ec || o_err !== ee) begin
                tests_failed++;
                $display("FAIL random%0d a=%h b=%h cin=%b sub=%b: lat=%0d sum=%h c=%b err=%b, need lat=%0d sum=%h c=%b err=%b",
                         n, av, bv, cv, sv, o_lat, o_sum, o_carry, o_err, D, es, ec, ee);
            end
            tests_run++;
            if (o_done_after !== 1'b0 || o_sum_hold !== es || o_carry_hold !== ec) begin
                tests_failed++;
                $display("FAIL random_hold%0d: done=%b sum=%h c=%b, need done=0 sum=%h c=%b",
                         n, o_done_after, o_sum_hold, o_carry_hold, es, ec);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_sub();
        test_err();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
